// File: rtl/l1i_cache_pkg.sv
// Shared cache definitions: FSM state encoding and default geometry, kept
// separate so a data-side cache can reuse them.
package l1i_cache_pkg;
   typedef enum logic {
      CACHE_IDLE   = 1'b0,
      CACHE_REFILL = 1'b1
   } cache_state_t;

   localparam int DEFAULT_LINES          = 16;
   localparam int DEFAULT_WORDS_PER_LINE = 4;
   localparam int WORD_BITS              = 32;
endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for a direct-mapped cache: combinational read by index,
// synchronous word/tag writes; no backpressure, writes always land at the edge.
module cache_line_array #(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int TAG_W          = 24
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic [$clog2(LINES)-1:0]          rd_index,
   input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_offset,
   output logic                              rd_valid,
   output logic [TAG_W-1:0]                  rd_tag,
   output logic [31:0]                       rd_word,
   input  logic                              wr_en,
   input  logic [$clog2(LINES)-1:0]          wr_index,
   input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_offset,
   input  logic [31:0]                       wr_data,
   input  logic                              tag_wr_en,
   input  logic [TAG_W-1:0]                  tag_wr_tag,
   input  logic                              tag_wr_valid,
   input  logic                              clear_all
);
   logic [31:0]      data_mem [LINES][WORDS_PER_LINE];
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [LINES-1:0] valid;

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_word  = data_mem[rd_index][rd_offset];

   // Payload storage is deliberately left out of reset; valid bits gate it.
   always_ff @(posedge clock) begin
      if (wr_en)
         data_mem[wr_index][wr_offset] <= wr_data;
      if (tag_wr_en)
         tag_mem[wr_index] <= tag_wr_tag;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid <= '0;
      end else begin
         if (clear_all)
            valid <= '0;
         if (tag_wr_en)
            valid[wr_index] <= tag_wr_valid;
      end
   end
endmodule

// File: rtl/l1i_cache.sv
// Direct-mapped read-only L1 instruction cache: zero-cycle hits, stalls fetch on
// a miss and refills one word per accepted memory cycle; honours mem_stall.
module l1i_cache
   import l1i_cache_pkg::*;
#(
   parameter int LINES          = DEFAULT_LINES,
   parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] cpu_address,
   input  logic        cpu_read,
   input  logic        flush,
   output logic [31:0] cpu_data,
   output logic        cpu_stall,
   output logic [31:0] mem_address,
   input  logic [31:0] mem_data,
   input  logic        mem_stall
);
   localparam int OB    = $clog2(WORDS_PER_LINE);
   localparam int IB    = $clog2(LINES);
   localparam int TAG_W = WORD_BITS - OB - IB - 2;

   cache_state_t   state;
   logic [31:0]    line_base;
   logic [OB:0]    issue_cnt;
   logic [OB-1:0]  capture_cnt;
   logic           pending;
   logic           flush_pend;

   logic [OB-1:0]    cpu_offset;
   logic [IB-1:0]    cpu_index;
   logic [TAG_W-1:0] cpu_tag;
   logic [IB-1:0]    refill_index;
   logic [TAG_W-1:0] refill_tag;
   logic             unused_byte_bits;

   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [31:0]      rd_word;

   logic hit, issue_ok, capture, last_capture, flush_eff, clear_all;

   assign cpu_offset       = cpu_address[OB+1:2];
   assign cpu_index        = cpu_address[OB+IB+1:OB+2];
   assign cpu_tag          = cpu_address[31:OB+IB+2];
   assign refill_index     = line_base[OB+IB+1:OB+2];
   assign refill_tag       = line_base[31:OB+IB+2];
   assign unused_byte_bits = &{1'b0, cpu_address[1:0]};

   assign hit          = cpu_read && rd_valid && (rd_tag == cpu_tag);
   assign issue_ok     = (state == CACHE_REFILL) && !mem_stall &&
                         (issue_cnt < (OB+1)'(WORDS_PER_LINE));
   assign capture      = (state == CACHE_REFILL) && pending;
   assign last_capture = capture && (capture_cnt == OB'(WORDS_PER_LINE - 1));
   // A flush seen at any point of the refill must leave the new line invalid.
   assign flush_eff    = flush_pend || flush;
   assign clear_all    = ((state == CACHE_IDLE) && flush) || (last_capture && flush_eff);

   always_comb begin
      cpu_data    = rd_word;
      cpu_stall   = 1'b1;
      mem_address = 32'h0;
      if (state == CACHE_REFILL)
         mem_address = line_base + {{(32-OB-3){1'b0}}, issue_cnt, 2'b00};
      else
         cpu_stall = cpu_read && !hit;
   end

   cache_line_array #(
      .LINES          (LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .TAG_W          (TAG_W)
   ) u_array (
      .clock        (clock),
      .reset_n      (reset_n),
      .rd_index     (cpu_index),
      .rd_offset    (cpu_offset),
      .rd_valid     (rd_valid),
      .rd_tag       (rd_tag),
      .rd_word      (rd_word),
      .wr_en        (capture),
      .wr_index     (refill_index),
      .wr_offset    (capture_cnt),
      .wr_data      (mem_data),
      .tag_wr_en    (last_capture),
      .tag_wr_tag   (refill_tag),
      .tag_wr_valid (!flush_eff),
      .clear_all    (clear_all)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= CACHE_IDLE;
         line_base   <= '0;
         issue_cnt   <= '0;
         capture_cnt <= '0;
         pending     <= 1'b0;
         flush_pend  <= 1'b0;
      end else begin
         case (state)
            CACHE_IDLE: begin
               if (cpu_read && !hit) begin
                  state       <= CACHE_REFILL;
                  line_base   <= {cpu_address[31:OB+2], {(OB+2){1'b0}}};
                  issue_cnt   <= '0;
                  capture_cnt <= '0;
                  pending     <= 1'b0;
                  flush_pend  <= 1'b0;
               end
            end
            CACHE_REFILL: begin
               pending <= issue_ok;
               if (issue_ok)
                  issue_cnt <= issue_cnt + 1'b1;
               if (capture)
                  capture_cnt <= capture_cnt + 1'b1;
               if (flush)
                  flush_pend <= 1'b1;
               if (last_capture) begin
                  state       <= CACHE_IDLE;
                  capture_cnt <= '0;
                  flush_pend  <= 1'b0;
               end
            end
            default: state <= CACHE_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_l1i_cache.sv
// Bench for l1i_cache: directed and random fetches against a line-residency model
// and a ROM returning addr ^ 32'hA5A5_0000 one cycle after the address.
module tb_l1i_cache;
   localparam int LINES = 16;
   localparam int W     = 4;
   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clock = 1'b0;
   logic        reset_n, cpu_read, flush, mem_stall, cpu_stall;
   logic [31:0] cpu_address, cpu_data, mem_address, mem_data;

   int checks = 0;
   int errors = 0;

   // Model: which line base is resident in each slot, and whether it is valid.
   bit          mv    [LINES];
   logic [31:0] mline [LINES];

   always #5 clock = ~clock;
   always @(posedge clock) mem_data <= mem_address ^ K;

   l1i_cache #(.LINES(LINES), .WORDS_PER_LINE(W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .cpu_address (cpu_address),
      .cpu_read    (cpu_read),
      .flush       (flush),
      .cpu_data    (cpu_data),
      .cpu_stall   (cpu_stall),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_stall   (mem_stall)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> $clog2(W*4)) & (LINES - 1));
   endfunction

   task automatic clear_model();
      for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
   endtask

   // Inputs change at the falling edge; outputs are sampled 1 ns later.
   task automatic drive(input logic rd, input logic [31:0] a, input logic st,
                        input logic fl, input logic rn);
      @(negedge clock);
      cpu_read = rd; cpu_address = a; mem_stall = st; flush = fl; reset_n = rn;
      #1;
   endtask

   task automatic fetch(input logic [31:0] addr, input logic [63:0] smask,
                        input int flush_at, input string name);
      logic [31:0] base, word;
      int idx, c, issued, fat;
      bit flushed, again, hit;
      base = addr & ~32'(W*4 - 1);
      word = {addr[31:2], 2'b00} ^ K;
      idx  = idx_of(addr);
      fat  = flush_at;
      c    = 0;
      drive(1'b1, addr, smask[0], fat == 0, 1'b1);
      hit = mv[idx] && (mline[idx] == base);
      chk({name, " stall@lookup"}, 32'(cpu_stall), 32'(!hit));
      if (fat == 0) clear_model();
      if (hit) begin
         chk({name, " hit data"}, cpu_data, word);
         chk({name, " hit mem_address"}, mem_address, 32'h0);
         return;
      end
      do begin
         again = 0; flushed = 0; issued = 0;
         while (issued < W && c < 60) begin
            c++;
            drive(1'b1, addr, (c < 64) ? smask[c] : 1'b0, c == fat, 1'b1);
            chk({name, " issue addr"}, mem_address, base + 32'(4 * issued));
            chk({name, " stall refill"}, 32'(cpu_stall), 32'd1);
            if (flush) flushed = 1;
            if (!mem_stall) issued++;
         end
         if (issued < W) begin
            chk({name, " issue budget"}, 32'(issued), 32'(W));
            return;
         end
         c++;
         drive(1'b1, addr, 1'b0, c == fat, 1'b1);
         chk({name, " stall last capture"}, 32'(cpu_stall), 32'd1);
         if (flush) flushed = 1;
         mline[idx] = base;
         mv[idx]    = !flushed;
         if (flushed) clear_model();
         c++;
         drive(1'b1, addr, 1'b0, 1'b0, 1'b1);
         if (!flushed) begin
            chk({name, " stall after fill"}, 32'(cpu_stall), 32'd0);
            chk({name, " data after fill"}, cpu_data, word);
            chk({name, " mem_address after fill"}, mem_address, 32'h0);
         end else begin
            chk({name, " re-miss after flushed fill"}, 32'(cpu_stall), 32'd1);
            again = 1;
            fat   = -1;
         end
      end while (again);
   endtask

   task automatic idle_flush();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("idle flush stall", 32'(cpu_stall), 32'd0);
      chk("idle flush mem_address", mem_address, 32'h0);
      clear_model();
   endtask

   task automatic reset_mid(input logic [31:0] addr, input int at);
      for (int c = 0; c <= at; c++) drive(1'b1, addr, 1'b0, 1'b0, c != at);
      clear_model();
      drive(1'b0, addr, 1'b0, 1'b0, 1'b1);
      chk("post-reset mem_address", mem_address, 32'h0);
      chk("post-reset stall idle", 32'(cpu_stall), 32'd0);
      cpu_read = 1'b1;
      #1;
      chk("post-reset stall on read", 32'(cpu_stall), 32'd1);
      cpu_read = 1'b0;
   endtask

   initial begin
      logic [63:0] m;
      logic [31:0] a;
      int r;
      reset_n = 1'b0; cpu_read = 1'b0; flush = 1'b0; mem_stall = 1'b0;
      cpu_address = 32'h0;
      clear_model();
      for (int i = 0; i < LINES; i++) mline[i] = 32'hFFFF_FFFF;
      repeat (3) @(posedge clock);
      drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      chk("reset stall with read", 32'(cpu_stall), 32'd1);
      chk("reset mem_address", mem_address, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("reset stall idle", 32'(cpu_stall), 32'd0);

      fetch(32'h40, 64'h0, -1, "fill40");
      fetch(32'h48, 64'h0, -1, "hit48");
      fetch(32'h44, 64'h0, -1, "hit44");
      fetch(32'h4C, 64'h0, -1, "hit4C");
      fetch(32'h100, 64'hC, -1, "fill100stall");
      fetch(32'h100, 64'h0, -1, "hit100");
      fetch(32'h104, 64'h0, -1, "hit104");
      fetch(32'h108, 64'h0, -1, "hit108");
      fetch(32'h10C, 64'h0, -1, "hit10C");
      fetch(32'h440, 64'h0, -1, "conflict440");
      fetch(32'h40, 64'h0, -1, "refetch40");
      idle_flush();
      fetch(32'h40, 64'h0, -1, "after flush40");
      fetch(32'h44, 64'h0, 0, "hit with flush");
      fetch(32'h44, 64'h0, -1, "miss after same-cycle flush");
      fetch(32'h80, 64'h0, 2, "flush mid refill");
      fetch(32'h84, 64'h0, -1, "hit after flushed refill");
      reset_mid(32'h200, 3);
      fetch(32'h200, 64'h0, -1, "fill200 after reset");
      fetch(32'h20C, 64'h0, -1, "hit20C");

      for (int n = 0; n < 40; n++) begin
         a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
             (32'($urandom_range(0, 3)) << 2);
         m = {$urandom, $urandom} & {$urandom, $urandom};
         r = $urandom_range(0, 9);
         if (r == 0) idle_flush();
         else fetch(a, m, (r == 1) ? int'($urandom_range(1, 4)) : -1, "random");
      end

      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
